// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweep block and its hold timer.
package truth_sweep_pkg;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;
  localparam logic [NUM_VEC-1:0] EXPECTED_DEFAULT = 16'h1FFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  // Mismatch count after folding in one sampled response.
  function automatic logic [4:0] next_mismatch(input logic [4:0] cnt,
                                               input logic       y,
                                               input logic       exp_bit);
    logic [4:0] res;
    if (y != exp_bit) begin
      res = cnt + 5'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/sweep_hold_counter.sv
// Hold timer: load clears it, tick counts up, expire marks the last hold cycle.
module sweep_hold_counter #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam logic [7:0] LAST_COUNT = 8'(HOLD_CYCLES - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear on load, advance on tick, saturate at the last hold cycle.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = 8'd0;
    end else if (tick_i && (count_q != LAST_COUNT)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/truth_table_sweep.sv
// Walks all 16 input vectors through a combinational stage, captures each
// response into a truth table and scores it against a golden table.
module truth_table_sweep
  import truth_sweep_pkg::*;
#(
  parameter int                 HOLD_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] EXPECTED    = EXPECTED_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  input  logic               y_in,
  output logic [VEC_W-1:0]   vec_idx,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] table_out,
  output logic [4:0]         mismatch_cnt,
  output logic               pass
);

  localparam logic [VEC_W-1:0] LAST_VEC = 4'(NUM_VEC - 1);

  sweep_state_e       state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_VEC-1:0] table_q, table_d;
  logic [4:0]         mm_q, mm_d, mm_next;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               hold_load, hold_tick, hold_expire;

  sweep_hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hold_load),
    .tick_i  (hold_tick),
    .expire_o(hold_expire)
  );

  assign mm_next = next_mismatch(mm_q, y_in, EXPECTED[vec_q]);

  // Sweep sequencing and capture; abort overrides every state transition.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    table_d   = table_q;
    mm_d      = mm_q;
    pass_d    = pass_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hold_load = 1'b0;
    hold_tick = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      if (state_q != ST_IDLE) begin
        pass_d = 1'b0;
      end else begin
        pass_d = pass_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_DRIVE;
            vec_d     = '0;
            table_d   = '0;
            mm_d      = 5'd0;
            pass_d    = 1'b0;
            busy_d    = 1'b1;
            hold_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DRIVE: begin
          hold_tick = 1'b1;
          if (hold_expire) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d = ST_DRIVE;
          end
        end
        ST_SAMPLE: begin
          table_d[vec_q] = y_in;
          mm_d           = mm_next;
          // The last vector parks vec_idx at 15 rather than wrapping.
          if (vec_q == LAST_VEC) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mm_next == 5'd0);
          end else begin
            state_d   = ST_DRIVE;
            vec_d     = vec_q + 4'd1;
            hold_load = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      table_q <= '0;
      mm_q    <= 5'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      mm_q    <= mm_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a            = vec_q[3];
  assign b            = vec_q[2];
  assign c            = vec_q[1];
  assign d            = vec_q[0];
  assign vec_idx      = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign mismatch_cnt = mm_q;
  assign pass         = pass_q;

endmodule
